// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution engines (conv_layer / conv_backward):
//   - conv_state_t : sequencer states IDLE / RUN / FINISH
//   - out_dim      : valid-convolution output side for a given input/kernel side
//   - total_steps  : number of MAC steps of one backward sweep
//   - acc_width    : accumulator width that cannot overflow before saturation
//   - idx_width    : index register width (at least 1 bit)
//   - sat          : clamp a wide signed value to a w-bit signed range
// -----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

    function automatic int out_dim(input int in_dim, input int kd);
        return in_dim - kd + 1;
    endfunction

    function automatic int total_steps(input int nk, input int kd, input int oh, input int ow);
        return nk * kd * kd * oh * ow;
    endfunction

    function automatic int acc_width(input int w, input int total, input int lr);
        return 2 * w + $clog2(total) + $clog2(lr + 1) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Result is still 64 bits wide; the caller truncates to w bits, which is
    // lossless once the value has been clamped.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/conv_index_counter.sv
// -----------------------------------------------------------------------------
// conv_index_counter
// Nested k / i / j / y / x counter, x innermost, one increment per 'step'.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : force all indices to 0 (has priority over step)
//   step         : advance by one position, wrapping to all-zero after the end
//   k,i,j,y,x    : current indices
//   group_last   : y and x are both at their maximum (end of a k/i/j group)
//   all_last     : the very last position of the sweep
// -----------------------------------------------------------------------------
module conv_index_counter import conv_pkg::*; #(
    parameter int NK = 2,
    parameter int KD = 3,
    parameter int OH = 1,
    parameter int OW = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       step,
    output logic [idx_width(NK)-1:0]   k,
    output logic [idx_width(KD)-1:0]   i,
    output logic [idx_width(KD)-1:0]   j,
    output logic [idx_width(OH)-1:0]   y,
    output logic [idx_width(OW)-1:0]   x,
    output logic                       group_last,
    output logic                       all_last
);

    localparam int KW = idx_width(NK);
    localparam int DW = idx_width(KD);
    localparam int YW = idx_width(OH);
    localparam int XW = idx_width(OW);

    logic [KW-1:0] k_reg;
    logic [DW-1:0] i_reg;
    logic [DW-1:0] j_reg;
    logic [YW-1:0] y_reg;
    logic [XW-1:0] x_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg <= '0;
            i_reg <= '0;
            j_reg <= '0;
            y_reg <= '0;
            x_reg <= '0;
        end else if (clear) begin
            k_reg <= '0;
            i_reg <= '0;
            j_reg <= '0;
            y_reg <= '0;
            x_reg <= '0;
        end else if (step) begin
            if (x_reg == XW'(OW - 1)) begin
                x_reg <= '0;
                if (y_reg == YW'(OH - 1)) begin
                    y_reg <= '0;
                    if (j_reg == DW'(KD - 1)) begin
                        j_reg <= '0;
                        if (i_reg == DW'(KD - 1)) begin
                            i_reg <= '0;
                            k_reg <= (k_reg == KW'(NK - 1)) ? '0 : k_reg + KW'(1);
                        end else begin
                            i_reg <= i_reg + DW'(1);
                        end
                    end else begin
                        j_reg <= j_reg + DW'(1);
                    end
                end else begin
                    y_reg <= y_reg + YW'(1);
                end
            end else begin
                x_reg <= x_reg + XW'(1);
            end
        end
    end

    assign k = k_reg;
    assign i = i_reg;
    assign j = j_reg;
    assign y = y_reg;
    assign x = x_reg;

    assign group_last = (y_reg == YW'(OH - 1)) && (x_reg == XW'(OW - 1));
    assign all_last   = group_last && (k_reg == KW'(NK - 1)) &&
                        (i_reg == DW'(KD - 1)) && (j_reg == DW'(KD - 1));

endmodule

// File: rtl/conv_backward.sv
// -----------------------------------------------------------------------------
// conv_backward
// Backward pass of a valid 2-D convolution layer. On 'start' (in IDLE) the
// image, output error and kernels are latched; one sweep over k/i/j/y/x then
// accumulates kernel gradients (writing SGD-updated kernels group by group)
// and the error propagated back to the input, which is saturated and
// registered in FINISH.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled only in IDLE
//   input_image     : forward-pass input            [IH][IW]
//   output_error    : error at the layer output     [NK][OH][OW]
//   input_kernels   : kernels before the update     [NK][KD][KD]
//   busy            : sweep in progress
//   done            : one-cycle pulse, results valid
//   output_kernels  : updated kernels               [NK][KD][KD]
//   input_error     : error propagated to the input [IH][IW]
// -----------------------------------------------------------------------------
module conv_backward import conv_pkg::*; #(
    parameter int WIDTH            = 8,
    parameter int NUM_KERNELS      = 2,
    parameter int KERNEL_DIM       = 3,
    parameter int INPUT_DIM_WIDTH  = 3,
    parameter int INPUT_DIM_HEIGHT = 3,
    parameter int LEARNING_RATE    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] input_image   [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
    input  logic signed [WIDTH-1:0] output_error  [NUM_KERNELS][INPUT_DIM_HEIGHT-KERNEL_DIM+1][INPUT_DIM_WIDTH-KERNEL_DIM+1],
    input  logic signed [WIDTH-1:0] input_kernels [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM],
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] output_kernels[NUM_KERNELS][KERNEL_DIM][KERNEL_DIM],
    output logic signed [WIDTH-1:0] input_error   [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH]
);

    localparam int NK    = NUM_KERNELS;
    localparam int KD    = KERNEL_DIM;
    localparam int IH    = INPUT_DIM_HEIGHT;
    localparam int IW    = INPUT_DIM_WIDTH;
    localparam int OH    = out_dim(IH, KD);
    localparam int OW    = out_dim(IW, KD);
    localparam int TOTAL = total_steps(NK, KD, OH, OW);
    localparam int ACC_W = acc_width(WIDTH, TOTAL, LEARNING_RATE);
    localparam int PW    = 2 * WIDTH;
    localparam int RW    = idx_width(IH);
    localparam int CW    = idx_width(IW);

    conv_state_t state_reg;
    logic        busy_reg;
    logic        done_reg;

    // Operands latched at start; the ports are free to change afterwards.
    logic signed [WIDTH-1:0] img_reg  [IH][IW];
    logic signed [WIDTH-1:0] err_reg  [NK][OH][OW];
    logic signed [WIDTH-1:0] kern_reg [NK][KD][KD];

    logic signed [WIDTH-1:0] kout_reg [NK][KD][KD];
    logic signed [WIDTH-1:0] ierr_reg [IH][IW];
    logic signed [ACC_W-1:0] dx_reg   [IH][IW];
    logic signed [ACC_W-1:0] g_reg;

    logic [idx_width(NK)-1:0] kk;
    logic [idx_width(KD)-1:0] ki;
    logic [idx_width(KD)-1:0] kj;
    logic [idx_width(OH)-1:0] ky;
    logic [idx_width(OW)-1:0] kx;
    logic                     group_last;
    logic                     all_last;

    // Counter sits at zero outside RUN, so the first MAC after start uses
    // position (0,0,0,0,0).
    conv_index_counter #(
        .NK (NK),
        .KD (KD),
        .OH (OH),
        .OW (OW)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_reg != RUN),
        .step       (state_reg == RUN),
        .k          (kk),
        .i          (ki),
        .j          (kj),
        .y          (ky),
        .x          (kx),
        .group_last (group_last),
        .all_last   (all_last)
    );

    logic [RW-1:0]           row_idx;
    logic [CW-1:0]           col_idx;
    logic signed [PW-1:0]    p_grad;
    logic signed [PW-1:0]    p_dx;
    logic signed [ACC_W-1:0] g_sum;
    logic signed [ACC_W-1:0] upd;
    logic signed [WIDTH-1:0] kern_new;
    logic signed [WIDTH-1:0] dx_sat [IH][IW];

    assign row_idx  = RW'(ki) + RW'(ky);
    assign col_idx  = CW'(kj) + CW'(kx);
    assign p_grad   = PW'(img_reg[row_idx][col_idx]) * PW'(err_reg[kk][ky][kx]);
    assign p_dx     = PW'(kern_reg[kk][ki][kj]) * PW'(err_reg[kk][ky][kx]);
    // g_sum already includes the current product, so on the last step of a
    // group it is the complete gradient for kernel tap (k,i,j).
    assign g_sum    = g_reg + ACC_W'(p_grad);
    assign upd      = ACC_W'(kern_reg[kk][ki][kj]) - ACC_W'(LEARNING_RATE) * g_sum;
    assign kern_new = WIDTH'(sat(64'(upd), WIDTH));

    genvar gi, gj;
    generate
        for (gi = 0; gi < IH; gi++) begin : g_row
            for (gj = 0; gj < IW; gj++) begin : g_col
                assign dx_sat[gi][gj] = WIDTH'(sat(64'(dx_reg[gi][gj]), WIDTH));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            g_reg     <= '0;
            for (int r = 0; r < IH; r++) begin
                for (int c = 0; c < IW; c++) begin
                    img_reg[r][c]  <= '0;
                    ierr_reg[r][c] <= '0;
                    dx_reg[r][c]   <= '0;
                end
            end
            for (int k = 0; k < NK; k++) begin
                for (int r = 0; r < OH; r++)
                    for (int c = 0; c < OW; c++)
                        err_reg[k][r][c] <= '0;
                for (int r = 0; r < KD; r++) begin
                    for (int c = 0; c < KD; c++) begin
                        kern_reg[k][r][c] <= '0;
                        kout_reg[k][r][c] <= '0;
                    end
                end
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        img_reg   <= input_image;
                        err_reg   <= output_error;
                        kern_reg  <= input_kernels;
                        g_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    g_reg <= group_last ? '0 : g_sum;
                    dx_reg[row_idx][col_idx] <= dx_reg[row_idx][col_idx] + ACC_W'(p_dx);
                    if (group_last)
                        kout_reg[kk][ki][kj] <= kern_new;
                    if (all_last)
                        state_reg <= FINISH;
                end
                FINISH: begin
                    for (int r = 0; r < IH; r++) begin
                        for (int c = 0; c < IW; c++) begin
                            ierr_reg[r][c] <= dx_sat[r][c];
                            dx_reg[r][c]   <= '0;
                        end
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign output_kernels = kout_reg;
    assign input_error    = ierr_reg;

endmodule

// File: tb/tb_conv_backward.sv
// -----------------------------------------------------------------------------
// tb_conv_backward
// Directed bench for conv_backward: default-parameter instance (dut) plus a
// 4x4 / KD=2 / NK=1 / LR=2 instance (dut2) checked against a loop model.
// -----------------------------------------------------------------------------
module tb_conv_backward;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic start2;

    always #5 clk = ~clk;

    // default instance: 3x3 image, 2 kernels 3x3, 1x1 output
    logic signed [7:0] img  [3][3];
    logic signed [7:0] err  [2][1][1];
    logic signed [7:0] kin  [2][3][3];
    logic signed [7:0] kout [2][3][3];
    logic signed [7:0] ierr [3][3];
    logic              busy;
    logic              done;

    // sweep instance: 4x4 image, 1 kernel 2x2, 3x3 output
    localparam int LR2 = 2;
    logic signed [7:0] img2  [4][4];
    logic signed [7:0] err2  [1][3][3];
    logic signed [7:0] kin2  [1][2][2];
    logic signed [7:0] kout2 [1][2][2];
    logic signed [7:0] ierr2 [4][4];
    logic              busy2;
    logic              done2;

    conv_backward dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .input_image    (img),
        .output_error   (err),
        .input_kernels  (kin),
        .busy           (busy),
        .done           (done),
        .output_kernels (kout),
        .input_error    (ierr)
    );

    conv_backward #(
        .WIDTH            (8),
        .NUM_KERNELS      (1),
        .KERNEL_DIM       (2),
        .INPUT_DIM_WIDTH  (4),
        .INPUT_DIM_HEIGHT (4),
        .LEARNING_RATE    (LR2)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start2),
        .input_image    (img2),
        .output_error   (err2),
        .input_kernels  (kin2),
        .busy           (busy2),
        .done           (done2),
        .output_kernels (kout2),
        .input_error    (ierr2)
    );

    // hand-computed results of the basic vector
    localparam int EXP_K [2][3][3] = '{
        '{'{0, -1, -2}, '{-2, -3, -4}, '{-4, -5, -6}},
        '{'{0, -2, -4}, '{-7, -9, -11}, '{-14, -16, -18}}
    };
    localparam int EXP_IE [3][3] = '{'{0, 0, 0}, '{-1, -1, -1}, '{-2, -2, -2}};

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec1();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                img[r][c]    = 8'(r * 3 + c);
                kin[0][r][c] = 8'(r);
                kin[1][r][c] = 8'(-r);
            end
        err[0][0][0] = 8'sd1;
        err[1][0][0] = 8'sd2;
    endtask

    task automatic set_sat();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                img[r][c]    = 8'sd100;
                kin[0][r][c] = 8'sd127;
                kin[1][r][c] = 8'sd127;
            end
        err[0][0][0] = 8'sd100;
        err[1][0][0] = 8'sd100;
    endtask

    task automatic check_vec1(input string tag);
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    check($sformatf("%s_k%0d_%0d%0d", tag, k, r, c), kout[k][r][c], EXP_K[k][r][c]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("%s_ie_%0d%0d", tag, r, c), ierr[r][c], EXP_IE[r][c]);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    check($sformatf("%s_k%0d_%0d%0d", tag, k, r, c), kout[k][r][c], 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("%s_ie_%0d%0d", tag, r, c), ierr[r][c], 0);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run1(input string tag, output int cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cycles = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                cycles = n;
                break;
            end
        end
        check({tag, "_latency"}, cycles, 19);
        $display("run %s: done after %0d cycles", tag, cycles);
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    int cyc;
    int pulses;
    int g;
    int s;
    int mk [2][2];
    int mie [4][4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        set_vec1();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img2[r][c] = 8'(r * 4 + c - 5);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                err2[0][y][x] = 8'(y * 3 + x - 3);
        kin2[0][0][0] = 8'sd3;
        kin2[0][0][1] = -8'sd2;
        kin2[0][1][0] = 8'sd1;
        kin2[0][1][1] = 8'sd4;

        // reset state
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_all_zero("rst");

        // basic vector, then back-to-back start in the done cycle with zero error
        run1("vec1", cyc);
        check_vec1("vec1");
        err[0][0][0] = 8'sd0;
        err[1][0][0] = 8'sd0;
        run1("b2b", cyc);
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    check($sformatf("b2b_k%0d_%0d%0d", k, r, c), kout[k][r][c], k == 0 ? r : -r);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("b2b_ie_%0d%0d", r, c), ierr[r][c], 0);
        @(posedge clk); #1;
        check("b2b_done_width", done, 0);
        check("b2b_busy_idle", busy, 0);

        // saturation
        set_sat();
        run1("sat", cyc);
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    check($sformatf("sat_k%0d_%0d%0d", k, r, c), kout[k][r][c], -128);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("sat_ie_%0d%0d", r, c), ierr[r][c], 127);

        // start held high during RUN while the inputs change
        set_vec1();
        start = 1'b1;
        @(posedge clk); #1;
        set_sat();
        cyc    = -1;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 15) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (cyc < 0) cyc = n;
            end
        end
        $display("run hold: done after %0d cycles, %0d pulses", cyc, pulses);
        check("hold_latency", cyc, 19);
        check("hold_pulses", pulses, 1);
        check_vec1("hold");

        // reset in the middle of RUN
        set_sat();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("run abort: reset asserted mid-run");
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_vec1();
        run1("after_abort", cyc);
        check_vec1("after_abort");

        // parameter sweep instance against a direct loop model
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                g = 0;
                for (int y = 0; y < 3; y++)
                    for (int x = 0; x < 3; x++)
                        g += int'(img2[i + y][j + x]) * int'(err2[0][y][x]);
                mk[i][j] = clamp8(int'(kin2[0][i][j]) - LR2 * g);
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        for (int y = 0; y < 3; y++)
                            for (int x = 0; x < 3; x++)
                                if (i + y == r && j + x == c)
                                    s += int'(kin2[0][i][j]) * int'(err2[0][y][x]);
                mie[r][c] = clamp8(s);
            end
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("sweep_busy", busy2, 1);
        cyc = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (done2) begin
                cyc = n;
                break;
            end
        end
        $display("run sweep: done after %0d cycles", cyc);
        check("sweep_latency", cyc, 37);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                check($sformatf("sweep_k_%0d%0d", i, j), kout2[0][i][j], mk[i][j]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("sweep_ie_%0d%0d", r, c), ierr2[r][c], mie[r][c]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
